// File: rtl/uart_byte_tx.sv
// UART transmitter: one 8N1 frame (optional parity) per send_en rising edge.
// All outputs are registered; send_busy falling edge paces the upstream cache.
module uart_byte_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       send_en,
    input  logic [7:0] send_byte_data,
    output logic       send_busy,
    output logic       tx_done,
    output logic       uart_txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             par_r, par_s;
    logic             en_q_r;
    logic             txd_r, txd_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             start_s;
    logic             bit_end_s;

    // Next state plus next values of the registered outputs; a rising edge seen
    // during the tx_done cycle is dropped because the frame is only just closing.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        par_s     = par_r;
        txd_s     = 1'b1;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        start_s   = send_en & ~en_q_r & ~done_r;
        bit_end_s = (cnt_r == CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_START;
                    cnt_s   = '0;
                    shift_s = send_byte_data;
                    par_s   = frame_parity(send_byte_data, ODD_BIT);
                    txd_s   = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                busy_s = 1'b1;
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cnt_s   = '0;
                    idx_s   = 3'd0;
                    txd_s   = shift_r[0];
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    txd_s = 1'b0;
                end
            end
            ST_DATA: begin
                busy_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s = '0;
                    if (idx_r == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_s = ST_PARITY;
                            txd_s   = par_r;
                        end else begin
                            state_s = ST_STOP;
                            txd_s   = 1'b1;
                        end
                    end else begin
                        idx_s = idx_r + 3'd1;
                        txd_s = shift_r[idx_r + 3'd1];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    txd_s = shift_r[idx_r];
                end
            end
            ST_PARITY: begin
                busy_s = 1'b1;
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    cnt_s   = '0;
                    txd_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    txd_s = par_r;
                end
            end
            ST_STOP: begin
                txd_s = 1'b1;
                if (bit_end_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r + CNT_W'(1);
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // State and output registers; en_q resets high so a held send_en is not a request.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            par_r   <= 1'b0;
            en_q_r  <= 1'b1;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            en_q_r  <= send_en;
            txd_r   <= txd_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign uart_txd  = txd_r;
    assign send_busy = busy_r;
    assign tx_done   = done_r;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances (no parity, even, odd) at CLKS_PER_BIT=10,
// each line checked cycle by cycle against a frame model built from the byte value.
module tb_uart_byte_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] send_en;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] txd;
    logic [7:0] data [3];
    logic [7:0] pace [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_byte_tx #(
            .CLK_FREQ  (1000),
            .BAUD      (100),
            .PARITY_EN ((g > 0) ? 1 : 0),
            .PARITY_ODD((g == 2) ? 1 : 0)
        ) u_dut (
            .sys_clk       (clk),
            .sys_rst       (rst[g]),
            .send_en       (send_en[g]),
            .send_byte_data(data[g]),
            .send_busy     (busy[g]),
            .tx_done       (done[g]),
            .uart_txd      (txd[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Instance 0: no parity; 1: even parity; 2: odd parity.
    function automatic int frame_bits(input int i);
        return (i > 0) ? 11 : 10;
    endfunction

    // Level of frame bit k (0 = start) for byte b on instance i.
    function automatic logic model_bit(input int i, input logic [7:0] b, input int k);
        logic [7:0] sh;
        int         p;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            sh = b >> (k - 1);
            return sh[0];
        end
        if (k == frame_bits(i) - 1) return 1'b1;
        p = ($countones(b) + ((i == 2) ? 1 : 0)) % 2;
        return p[0];
    endfunction

    task automatic idle_cycles(input int i, input int n);
        repeat (n) begin
            @(negedge clk);
            check_eq($sformatf("idle_done d%0d", i), done[i], 1'b0);
            check_eq($sformatf("idle_busy d%0d", i), busy[i], 1'b0);
            check_eq($sformatf("idle_txd d%0d", i), txd[i], 1'b1);
        end
    endtask

    // Raise send_en with byte b and follow the whole frame; optionally disturb the
    // inputs mid-frame, or apply reset at frame cycle abort_at.
    task automatic send_frame(input int i, input logic [7:0] b, input bit disturb, input int abort_at);
        int len;
        int k;
        len = frame_bits(i) * CPB;
        if (send_en[i]) begin
            send_en[i] = 1'b0;
            @(negedge clk);
        end
        check_eq($sformatf("pre_busy d%0d", i), busy[i], 1'b0);
        check_eq($sformatf("pre_txd d%0d", i), txd[i], 1'b1);
        data[i]    = b;
        send_en[i] = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            k = c / CPB;
            check_eq($sformatf("txd d%0d byte %0h bit %0d cyc %0d", i, b, k, c), txd[i], model_bit(i, b, k));
            check_eq($sformatf("busy d%0d cyc %0d", i, c), busy[i], 1'b1);
            check_eq($sformatf("done_early d%0d cyc %0d", i, c), done[i], 1'b0);
            if (c == abort_at) begin
                rst[i] = 1'b1;
                @(negedge clk);
                rst[i]     = 1'b0;
                send_en[i] = 1'b0;
                check_eq($sformatf("abort_txd d%0d", i), txd[i], 1'b1);
                check_eq($sformatf("abort_busy d%0d", i), busy[i], 1'b0);
                check_eq($sformatf("abort_done d%0d", i), done[i], 1'b0);
                idle_cycles(i, 2 * CPB);
                return;
            end
            if (disturb) begin
                if (c == 2) send_en[i] = 1'b0;
                if (c == len / 2) begin
                    data[i]    = (b == 8'hFF) ? 8'h00 : 8'hFF;
                    send_en[i] = 1'b1;
                end
                if (c == len / 2 + 3) send_en[i] = 1'b0;
            end else if (c == 1) begin
                send_en[i] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq($sformatf("done_pulse d%0d", i), done[i], 1'b1);
        check_eq($sformatf("busy_fall d%0d", i), busy[i], 1'b0);
        check_eq($sformatf("stop_txd d%0d", i), txd[i], 1'b1);
    endtask

    initial begin
        rst     = 3'b111;
        send_en = 3'b111;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_txd d%0d", i), txd[i], 1'b1);
            check_eq($sformatf("rst_busy d%0d", i), busy[i], 1'b0);
            check_eq($sformatf("rst_done d%0d", i), done[i], 1'b0);
        end
        rst = 3'b000;
        for (int i = 0; i < 3; i++) idle_cycles(i, 50);
        send_en = 3'b000;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            send_frame(i, 8'hA5, 1'b0, -1);
            idle_cycles(i, 1);
            send_frame(i, 8'h01, 1'b0, -1);
            idle_cycles(i, 1);
        end

        send_frame(0, 8'h3C, 1'b1, -1);
        idle_cycles(0, 2 * CPB);

        // an edge raised in the tx_done cycle itself must not start a frame
        send_frame(0, 8'h5A, 1'b0, -1);
        send_en[0] = 1'b1;
        idle_cycles(0, 5);

        send_frame(2, 8'h80, 1'b0, -1);
        idle_cycles(2, 1);
        send_frame(2, 8'h7E, 1'b0, -1);
        idle_cycles(2, 1);

        for (int n = 0; n < 4; n++) begin
            send_frame(0, pace[n], 1'b0, -1);
            idle_cycles(0, 2);
        end

        send_frame(0, 8'hC3, 1'b0, 44);
        send_frame(0, 8'h96, 1'b0, -1);
        idle_cycles(0, 1);

        for (int r = 0; r < 18; r++) begin
            int         i;
            logic [7:0] b;
            i = r % 3;
            b = 8'($urandom);
            send_frame(i, b, 1'($urandom_range(0, 1)), -1);
            idle_cycles(i, $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
